// File: rtl/capture_ram_writer_pkg.sv
// rtl/capture_ram_writer_pkg.sv - shared states and constants for the capture RAM writer
package capture_ram_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [3:0]  WE_FULL    = 4'hF;
    localparam logic [3:0]  WE_LOW     = 4'h3;

endpackage

// File: rtl/capture_ram_writer.sv
// rtl/capture_ram_writer.sv - packs 16-bit samples in pairs and writes them to BRAM port A
module capture_ram_writer
    import capture_ram_writer_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        capture_start,
    input  logic        capture_stop,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic        rsta,
    output logic        ena,
    output logic [3:0]  wea,
    output logic [31:0] addra,
    output logic [31:0] dina,
    output logic        busy,
    output logic        done,
    output logic [31:0] words_written
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);
    localparam logic [31:0] STRIDE  = 32'(WORD_BYTES);

    state_t      state_q, state_d;
    logic        half_q;
    logic [15:0] hold_q;
    logic [31:0] wr_addr_q;
    logic [31:0] ww_q;
    logic        ena_q;
    logic [3:0]  wea_q;
    logic [31:0] addra_q;
    logic [31:0] dina_q;

    logic accept;
    logic arm;
    logic full_wr;
    logic low_take;
    logic flush_wr;

    assign s_ready  = (state_q == ST_CAPTURE) && (ww_q != DEPTH_W);
    assign accept   = s_valid && s_ready;
    assign full_wr  = accept && half_q;
    assign low_take = accept && !half_q;
    assign flush_wr = (state_q == ST_FLUSH);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        arm     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (capture_start) begin
                    state_d = ST_CAPTURE;
                    arm     = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // After a stop, a dangling half-word exists exactly when half
                // and this cycle's acceptance disagree; only then is a flush needed.
                if (capture_stop) begin
                    state_d = (half_q ^ accept) ? ST_FLUSH : ST_DONE;
                end else if (ww_q == DEPTH_W) begin
                    state_d = ST_DONE;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (capture_start) begin
                    state_d = ST_CAPTURE;
                    arm     = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            half_q    <= 1'b0;
            hold_q    <= 16'h0000;
            wr_addr_q <= BASE_ADDR;
            ww_q      <= 32'd0;
            ena_q     <= 1'b0;
            wea_q     <= 4'h0;
            addra_q   <= BASE_ADDR;
            dina_q    <= 32'd0;
        end else begin
            ena_q <= 1'b0;
            wea_q <= 4'h0;
            if (arm) begin
                half_q    <= 1'b0;
                hold_q    <= 16'h0000;
                wr_addr_q <= BASE_ADDR;
                ww_q      <= 32'd0;
            end else if (flush_wr) begin
                ena_q     <= 1'b1;
                wea_q     <= WE_LOW;
                dina_q    <= {16'h0000, hold_q};
                addra_q   <= wr_addr_q;
                wr_addr_q <= wr_addr_q + STRIDE;
                ww_q      <= ww_q + 32'd1;
                half_q    <= 1'b0;
            end else if (full_wr) begin
                ena_q     <= 1'b1;
                wea_q     <= WE_FULL;
                dina_q    <= {s_data, hold_q};
                addra_q   <= wr_addr_q;
                wr_addr_q <= wr_addr_q + STRIDE;
                ww_q      <= ww_q + 32'd1;
                half_q    <= 1'b0;
            end else if (low_take) begin
                hold_q <= s_data;
                half_q <= 1'b1;
            end
        end
    end

    assign rsta          = 1'b0;
    assign ena           = ena_q;
    assign wea           = wea_q;
    assign addra         = addra_q;
    assign dina          = dina_q;
    assign busy          = (state_q == ST_CAPTURE) || (state_q == ST_FLUSH);
    assign done          = (state_q == ST_DONE);
    assign words_written = ww_q;

endmodule
